// File: rtl/toeplitz_writer_if.sv
// Toeplitz writer bus: start request, packed result-vector handshake and memory write port.
interface toeplitz_writer_if #(
    parameter int unsigned MaxWidth   = 9,
    parameter int unsigned Depth      = 32,
    parameter int unsigned DataWidth  = 8,
    parameter int unsigned AddrWidth  = $clog2(Depth),
    parameter int unsigned CountWidth = $clog2(MaxWidth + 1)
);
    logic                            writeEn;
    logic [AddrWidth-1:0]            startAddr;
    logic [AddrWidth-1:0]            outputSize;
    logic [MaxWidth*DataWidth-1:0]   dataIn;
    logic                            dataValid;
    logic [CountWidth-1:0]           validCount;
    logic                            dataReady;
    logic                            writeReq;
    logic [AddrWidth-1:0]            writeAddr;
    logic [DataWidth-1:0]            writeData;
    logic                            finished;

    // Upstream / controller side
    modport master (
        output writeEn, startAddr, outputSize, dataIn, dataValid, validCount,
        input  dataReady, writeReq, writeAddr, writeData, finished
    );

    // Writer side
    modport slave (
        input  writeEn, startAddr, outputSize, dataIn, dataValid, validCount,
        output dataReady, writeReq, writeAddr, writeData, finished
    );
endinterface

// File: rtl/toeplitz_writer.sv
// Toeplitz writeback: serializes packed result vectors, one byte per cycle, into a
// row-major outputSize x outputSize map at startAddr.
// Optional build macro WRITER_RELU_EN: clamp negative (signed) lanes to zero on write.
module toeplitz_writer #(
    parameter int unsigned MaxWidth   = 9,
    parameter int unsigned Depth      = 32,
    parameter int unsigned DataWidth  = 8,
    parameter int unsigned AddrWidth  = $clog2(Depth),
    parameter int unsigned CountWidth = $clog2(MaxWidth + 1)
) (
    input  logic                clk,
    input  logic                rst,
    toeplitz_writer_if.slave    bus
);

    localparam int unsigned TotalWidth = 2 * AddrWidth;

    typedef logic [MaxWidth-1:0][DataWidth-1:0] laneVecT;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        WAITING,
        WRITE,
        DONE
    } stateT;

    stateT                  state, stateNext;
    logic [AddrWidth-1:0]   startQ, startD;
    logic [AddrWidth-1:0]   sizeQ, sizeD;
    logic [TotalWidth-1:0]  totalQ, totalD;
    logic [TotalWidth-1:0]  writtenQ, writtenD;
    logic [AddrWidth-1:0]   addrQ, addrD;
    laneVecT                laneBufQ, laneBufD;
    logic [CountWidth-1:0]  lanesQ, lanesD;
    logic [CountWidth-1:0]  laneQ, laneD;
    logic                   dataReadyQ, dataReadyD;
    logic                   writeReqQ, writeReqD;
    logic [AddrWidth-1:0]   writeAddrQ, writeAddrD;
    logic [DataWidth-1:0]   writeDataQ, writeDataD;
    logic                   finishedQ, finishedD;

    logic [TotalWidth-1:0]  mapTotal;
    logic [CountWidth-1:0]  validLanes;

    // Select one lane out of a packed vector; out-of-range indices read as zero
    function automatic logic [DataWidth-1:0] laneOf(input laneVecT vec, input logic [CountWidth-1:0] idx);
        logic [DataWidth-1:0] r;
        r = '0;
        for (int i = 0; i < int'(MaxWidth); i++) begin
            if (idx == CountWidth'(i)) begin
                r = vec[i];
            end
        end
        return r;
    endfunction

    // Output-byte transform applied right at the writeData register
    function automatic logic [DataWidth-1:0] clampLane(input logic [DataWidth-1:0] v);
`ifdef WRITER_RELU_EN
        return v[DataWidth-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    // Map size and lane-count clamp
    assign mapTotal   = TotalWidth'(sizeQ) * TotalWidth'(sizeQ);
    assign validLanes = (bus.validCount > CountWidth'(MaxWidth)) ? CountWidth'(MaxWidth) : bus.validCount;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            startQ     <= '0;
            sizeQ      <= '0;
            totalQ     <= '0;
            writtenQ   <= '0;
            addrQ      <= '0;
            laneBufQ   <= '0;
            lanesQ     <= '0;
            laneQ      <= '0;
            dataReadyQ <= 1'b0;
            writeReqQ  <= 1'b0;
            writeAddrQ <= '0;
            writeDataQ <= '0;
            finishedQ  <= 1'b0;
        end else begin
            state      <= stateNext;
            startQ     <= startD;
            sizeQ      <= sizeD;
            totalQ     <= totalD;
            writtenQ   <= writtenD;
            addrQ      <= addrD;
            laneBufQ   <= laneBufD;
            lanesQ     <= lanesD;
            laneQ      <= laneD;
            dataReadyQ <= dataReadyD;
            writeReqQ  <= writeReqD;
            writeAddrQ <= writeAddrD;
            writeDataQ <= writeDataD;
            finishedQ  <= finishedD;
        end
    end

    // Next-state and next-output logic; addrQ is the address of the next write,
    // which equals startAddr + row*outputSize + col because the map is row-major and contiguous
    always_comb begin
        stateNext  = state;
        startD     = startQ;
        sizeD      = sizeQ;
        totalD     = totalQ;
        writtenD   = writtenQ;
        addrD      = addrQ;
        laneBufD   = laneBufQ;
        lanesD     = lanesQ;
        laneD      = laneQ;
        writeReqD  = 1'b0;
        writeAddrD = writeAddrQ;
        writeDataD = writeDataQ;
        dataReadyD = 1'b0;
        finishedD  = 1'b0;

        unique case (state)
            IDLE: begin
                if (bus.writeEn) begin
                    startD    = bus.startAddr;
                    sizeD     = bus.outputSize;
                    stateNext = INIT;
                end
            end
            INIT: begin
                totalD    = mapTotal;
                writtenD  = '0;
                addrD     = startQ;
                stateNext = (mapTotal == '0) ? DONE : WAITING;
            end
            WAITING: begin
                if (bus.dataValid && (validLanes != '0)) begin
                    laneBufD   = laneVecT'(bus.dataIn);
                    lanesD     = validLanes;
                    laneD      = '0;
                    writeReqD  = 1'b1;
                    writeAddrD = addrQ;
                    writeDataD = clampLane(laneOf(laneVecT'(bus.dataIn), '0));
                    addrD      = addrQ + AddrWidth'(1);
                    writtenD   = writtenQ + TotalWidth'(1);
                    stateNext  = WRITE;
                end
            end
            WRITE: begin
                if (writtenQ == totalQ) begin
                    stateNext = DONE;
                end else if (laneQ == lanesQ - CountWidth'(1)) begin
                    stateNext = WAITING;
                end else begin
                    laneD      = laneQ + CountWidth'(1);
                    writeReqD  = 1'b1;
                    writeAddrD = addrQ;
                    writeDataD = clampLane(laneOf(laneBufQ, laneQ + CountWidth'(1)));
                    addrD      = addrQ + AddrWidth'(1);
                    writtenD   = writtenQ + TotalWidth'(1);
                end
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase

        dataReadyD = (stateNext == WAITING);
        finishedD  = (stateNext == DONE);
    end

    assign bus.dataReady = dataReadyQ;
    assign bus.writeReq  = writeReqQ;
    assign bus.writeAddr = writeAddrQ;
    assign bus.writeData = writeDataQ;
    assign bus.finished  = finishedQ;

endmodule

// File: tb/tb_toeplitz_writer.sv
// Directed bench for toeplitz_writer: table of map/vector cases plus a mid-write reset sequence.
module tb_toeplitz_writer;

    localparam int unsigned MaxWidth   = 9;
    localparam int unsigned Depth      = 32;
    localparam int unsigned DataWidth  = 8;
    localparam int unsigned AddrWidth  = 5;
    localparam int unsigned CountWidth = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    toeplitz_writer_if #(
        .MaxWidth(MaxWidth), .Depth(Depth), .DataWidth(DataWidth),
        .AddrWidth(AddrWidth), .CountWidth(CountWidth)
    ) bus ();

    toeplitz_writer #(
        .MaxWidth(MaxWidth), .Depth(Depth), .DataWidth(DataWidth),
        .AddrWidth(AddrWidth), .CountWidth(CountWidth)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct packed {
        logic [4:0]             size;
        logic [4:0]             start;
        logic [1:0]             nVec;
        logic [1:0][3:0]        cnt;
        logic [1:0][8:0][7:0]   vec;
        logic [3:0]             expN;
        logic [8:0][4:0]        expAddr;
        logic [8:0][7:0]        expData;
        logic [4:0]             expFin;
    } caseT;

    caseT tbl [7];
    int   nChecks = 0;
    int   nFail   = 0;

    task automatic check(input string name, input int act, input int exp);
        nChecks++;
        if (act != exp) begin
            nFail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Start a map, feed vectors whenever dataReady is seen, collect writes until finished
    task automatic runCase(input caseT c, input string name);
        int nw, fin, lastW, vi, overlap, rdyBad, extraFin;
        nw = 0; fin = -1; lastW = -1; vi = 0; overlap = 0; rdyBad = 0; extraFin = 0;
        @(negedge clk);
        bus.startAddr  = c.start;
        bus.outputSize = c.size;
        bus.dataValid  = 1'b0;
        bus.writeEn    = 1'b1;
        for (int cyc = 1; cyc <= 60 && fin < 0; cyc++) begin
            @(negedge clk);
            bus.writeEn = 1'b0;
            if (bus.writeReq) begin
                if (nw < 9) begin
                    check($sformatf("%s addr%0d", name, nw), int'(bus.writeAddr), int'(c.expAddr[nw]));
                    check($sformatf("%s data%0d", name, nw), int'(bus.writeData), int'(c.expData[nw]));
                end
                nw++;
                lastW = cyc;
                if (bus.dataReady) rdyBad++;
                if (bus.finished) overlap++;
            end
            if (bus.finished) fin = cyc;
            if (bus.dataReady && vi < int'(c.nVec)) begin
                bus.dataIn     = c.vec[vi];
                bus.validCount = c.cnt[vi];
                bus.dataValid  = 1'b1;
                vi++;
            end else begin
                bus.dataValid = 1'b0;
            end
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (bus.writeReq) nw++;
            if (bus.finished) extraFin++;
        end
        check({name, " writes"}, nw, int'(c.expN));
        check({name, " finishCycle"}, fin, int'(c.expFin));
        if (c.expN != 0) check({name, " lastWriteCycle"}, lastW, int'(c.expFin) - 1);
        check({name, " readyOrFinishDuringWrite"}, rdyBad + overlap, 0);
        check({name, " finishedPulseWidth"}, extraFin, 0);
    endtask

    initial begin
        for (int t = 0; t < 7; t++) tbl[t] = '0;

        // Basic 3x3 map at 4, one full vector
        tbl[0].size = 3; tbl[0].start = 4; tbl[0].nVec = 1; tbl[0].cnt[0] = 9;
        for (int i = 0; i < 9; i++) begin
            tbl[0].vec[0][i] = 8'(i + 1); tbl[0].expAddr[i] = 5'(4 + i); tbl[0].expData[i] = 8'(i + 1);
        end
        tbl[0].expN = 9; tbl[0].expFin = 12;

        // Partial vectors 3 + 1 on a 2x2 map
        tbl[1].size = 2; tbl[1].start = 0; tbl[1].nVec = 2; tbl[1].cnt[0] = 3; tbl[1].cnt[1] = 1;
        tbl[1].vec[0][0] = 8'd10; tbl[1].vec[0][1] = 8'd11; tbl[1].vec[0][2] = 8'd12; tbl[1].vec[0][3] = 8'd99;
        tbl[1].vec[1][0] = 8'd13; tbl[1].vec[1][1] = 8'd98;
        for (int i = 0; i < 4; i++) begin
            tbl[1].expAddr[i] = 5'(i); tbl[1].expData[i] = 8'(10 + i);
        end
        tbl[1].expN = 4; tbl[1].expFin = 8;

        // Overflow: 9 lanes into a 4-entry map, lanes 4..8 discarded
        tbl[2].size = 2; tbl[2].start = 0; tbl[2].nVec = 1; tbl[2].cnt[0] = 9;
        for (int i = 0; i < 9; i++) tbl[2].vec[0][i] = 8'(8'h21 + i);
        for (int i = 0; i < 4; i++) begin
            tbl[2].expAddr[i] = 5'(i); tbl[2].expData[i] = 8'(8'h21 + i);
        end
        tbl[2].expN = 4; tbl[2].expFin = 7;

        // Address wrap past Depth-1
        tbl[3].size = 2; tbl[3].start = 30; tbl[3].nVec = 1; tbl[3].cnt[0] = 4;
        for (int i = 0; i < 4; i++) begin
            tbl[3].vec[0][i] = 8'(8'h31 + i); tbl[3].expData[i] = 8'(8'h31 + i);
        end
        tbl[3].expAddr[0] = 5'd30; tbl[3].expAddr[1] = 5'd31; tbl[3].expAddr[2] = 5'd0; tbl[3].expAddr[3] = 5'd1;
        tbl[3].expN = 4; tbl[3].expFin = 7;

        // Zero-size map: no writes, finished two cycles after writeEn
        tbl[4].size = 0; tbl[4].start = 7; tbl[4].nVec = 0; tbl[4].expN = 0; tbl[4].expFin = 2;

        // No-op vector (count 0) then an over-count vector clamped to 9 lanes
        tbl[5].size = 3; tbl[5].start = 2; tbl[5].nVec = 2; tbl[5].cnt[0] = 0; tbl[5].cnt[1] = 15;
        for (int i = 0; i < 9; i++) begin
            tbl[5].vec[0][i] = 8'hEE;
            tbl[5].vec[1][i] = 8'(8'h41 + i); tbl[5].expAddr[i] = 5'(2 + i); tbl[5].expData[i] = 8'(8'h41 + i);
        end
        tbl[5].expN = 9; tbl[5].expFin = 13;

        // Sign-boundary bytes
        tbl[6].size = 2; tbl[6].start = 5; tbl[6].nVec = 2; tbl[6].cnt[0] = 3; tbl[6].cnt[1] = 1;
        tbl[6].vec[0][0] = 8'hFF; tbl[6].vec[0][1] = 8'h80; tbl[6].vec[0][2] = 8'h05; tbl[6].vec[1][0] = 8'h7F;
        for (int i = 0; i < 4; i++) tbl[6].expAddr[i] = 5'(5 + i);
`ifdef WRITER_RELU_EN
        tbl[6].expData[0] = 8'h00; tbl[6].expData[1] = 8'h00;
`else
        tbl[6].expData[0] = 8'hFF; tbl[6].expData[1] = 8'h80;
`endif
        tbl[6].expData[2] = 8'h05; tbl[6].expData[3] = 8'h7F;
        tbl[6].expN = 4; tbl[6].expFin = 8;

        rst            = 1'b1;
        bus.writeEn    = 1'b0;
        bus.startAddr  = '0;
        bus.outputSize = '0;
        bus.dataIn     = '0;
        bus.dataValid  = 1'b0;
        bus.validCount = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset dataReady", int'(bus.dataReady), 0);
        check("reset writeReq", int'(bus.writeReq), 0);
        check("reset writeAddr", int'(bus.writeAddr), 0);
        check("reset writeData", int'(bus.writeData), 0);
        check("reset finished", int'(bus.finished), 0);
        rst = 1'b0;

        for (int t = 0; t < 7; t++) runCase(tbl[t], $sformatf("case%0d", t));

        // Reset during the second write of a 9-lane vector
        @(negedge clk);
        bus.startAddr  = 5'd0;
        bus.outputSize = 5'd3;
        bus.writeEn    = 1'b1;
        @(negedge clk);
        bus.writeEn = 1'b0;
        @(negedge clk);
        check("midReset waitReady", int'(bus.dataReady), 1);
        bus.dataIn     = tbl[0].vec[0];
        bus.validCount = 4'd9;
        bus.dataValid  = 1'b1;
        @(negedge clk);
        bus.dataValid = 1'b0;
        @(negedge clk);
        check("midReset secondWriteReq", int'(bus.writeReq), 1);
        check("midReset secondWriteData", int'(bus.writeData), 2);
        rst = 1'b1;
        bus.dataValid = 1'b1;
        @(negedge clk);
        check("midReset writeReq", int'(bus.writeReq), 0);
        check("midReset writeAddr", int'(bus.writeAddr), 0);
        check("midReset writeData", int'(bus.writeData), 0);
        check("midReset dataReady", int'(bus.dataReady), 0);
        check("midReset finished", int'(bus.finished), 0);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("postReset idle%0d", k), int'({bus.writeReq, bus.dataReady, bus.finished}), 0);
        end
        bus.dataValid = 1'b0;

        runCase(tbl[0], "afterReset");

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
